rr_arbiter8: RTL
================

Name: rr_arbiter8

Overview:
Round-robin arbiter that shares one resource among 8 requesters. It issues a one-hot grant, produced from the 3-bit winner index through the team's 3-to-8 decoder, together with the encoded index. It sits between requester ports and a shared datapath and bounds tenure with a hold-cycle limit. It sequences ownership through an IDLE/GRANT state machine with a rotating priority pointer.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant; legal range 1..255.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  arbitration enable; gates new grants only
req  input  8  request vector; bit i = requester i
gnt  output  8  one-hot grant; equals decode of gnt_idx when gnt_valid=1, else 8'h00
gnt_idx  output  3  index of current owner
gnt_valid  output  1  a grant is active
timeout  output  1  one-cycle pulse when a grant is forcibly revoked at MAX_HOLD

Behaviour:
- Reset values (rst=1 at an edge):
  - state=IDLE, ptr=3'd0, hold_cnt=8'd0.
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - rst takes priority over all other inputs. rst mid-grant drops gnt on the next edge.
- All outputs are registered. gnt is 8'h00 whenever gnt_valid=0.
- IDLE:
  - If en=1 and req!=0, select the first set bit searching ptr, ptr+1, ..., ptr+7, with modulo-8 wrap.
  - Next cycle: state=GRANT, gnt_idx=winner, gnt=one-hot(winner), gnt_valid=1, hold_cnt=0.
  - Otherwise stay IDLE with outputs at zero.
  - Latency from req rising to gnt is 1 cycle.
- GRANT, evaluated each edge:
  - Voluntary release: req[gnt_idx]=0 → state=IDLE, gnt=0, gnt_valid=0, ptr=gnt_idx+1 (mod 8), timeout=0.
  - Forced release: req[gnt_idx]=1 and hold_cnt==MAX_HOLD-1 → same as voluntary release, plus timeout=1 for exactly one cycle.
  - Otherwise: hold_cnt increments, and gnt, gnt_idx and gnt_valid stay unchanged.
  - Requests from other requesters are ignored while in GRANT.
  - en is ignored in GRANT; a grant in progress completes even if en drops.
- Grant tenure:
  - gnt_valid stays high for at most MAX_HOLD cycles.
  - Each release is followed by exactly one IDLE cycle with gnt=0 (a dead cycle) before the next grant. Maximum grant duty is therefore MAX_HOLD/(MAX_HOLD+1).
- MAX_HOLD=1: every grant lasts 1 cycle and, if the requester still requests, ends with timeout=1.
- Fairness: the pointer moves past the previous owner, so any continuously asserted request is granted within 7 other tenures.
- Pointer wrap: winner 7 → ptr=0.
- Simultaneous requests in IDLE: the lowest index at or after ptr, with wrap, wins.
- hold_cnt never exceeds MAX_HOLD-1. It is cleared on every new grant.
- timeout is 0 in all cycles except the cycle immediately after a forced release edge.

Test Plan:
1. Reset then single request: rst=1 for 2 cycles, then req=8'h04, en=1 → gnt=8'h04 and gnt_idx=2 one cycle later, gnt_valid=1. Drop req → next edge gnt=0, ptr=3.
2. Rotation: req=8'hFF held, MAX_HOLD=16, each owner releases by clearing its own bit after 3 cycles and reasserting later → grant order 0,1,2,...,7,0, with one zero-gnt cycle between each.
3. Wrap priority: ptr=6 (after granting 5), req=8'h03 → gnt_idx=0. Then req=8'h81 after releasing 0 → gnt_idx=7.
4. Timeout: MAX_HOLD=4, req=8'h10 held constant → gnt=8'h10 for exactly 4 cycles, timeout=1 in the following cycle with gnt=0, then a regrant to 4 (only requester) after 1 idle cycle.
5. Enable gating: en=0, req=8'h20 → no grant for 10 cycles. Drop en mid-grant → grant continues until release, and no new grant follows while en=0.
6. Reset mid-grant: gnt=8'h08 active, rst=1 for 1 cycle → next edge gnt=0, gnt_valid=0, gnt_idx=0. With req=8'h09 afterwards, winner is 0 (ptr reset to 0).

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a rotating priority pointer and a
// bounded grant tenure; the current owner is forcibly released at MAX_HOLD.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_valid;
    logic       r_timeout;

    logic [7:0] w_rot;
    logic [2:0] w_off;
    logic       w_found;
    logic [2:0] w_win;
    logic [7:0] w_dec;
    logic       w_own_req;
    logic       w_release;

    // Rotate so that bit 0 is the requester at r_ptr; the lowest set bit
    // of the rotated vector is then the winner's distance from the pointer.
    always_comb begin
        w_rot   = 8'({req, req} >> r_ptr);
        w_off   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!w_found && w_rot[i]) begin
                w_off   = 3'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_win     = r_ptr + w_off;
    assign w_dec     = 8'b0000_0001 << w_win;
    assign w_own_req = req[r_gnt_idx];
    assign w_release = !w_own_req || (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (en && w_found) begin
                        r_state     <= GRANT;
                        r_gnt       <= w_dec;
                        r_gnt_idx   <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        // timeout marks only a release forced while still requested
                        r_state     <= IDLE;
                        r_gnt       <= '0;
                        r_gnt_idx   <= '0;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_idx + 3'd1;
                        r_hold_cnt  <= '0;
                        r_timeout   <= w_own_req;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt + 8'd1;
                        r_timeout   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
